// File: rtl/cache_pkg.sv
// Shared state encoding and width helpers for the 2-way set-associative read cache.
package cache_pkg;

   typedef enum logic [2:0] {
      StIdle,
      StLookup,
      StRefill,
      StResp,
      StFlush
   } cache_state_e;

   function automatic int unsigned calc_off_w(input int unsigned mem_w,
                                              input int unsigned core_w);
      return $clog2(mem_w / core_w);
   endfunction

   function automatic int unsigned calc_index_w(input int unsigned sets);
      return $clog2(sets);
   endfunction

   function automatic int unsigned calc_tag_w(input int unsigned addr_w,
                                              input int unsigned sets,
                                              input int unsigned mem_w,
                                              input int unsigned core_w);
      return addr_w - calc_index_w(sets) - calc_off_w(mem_w, core_w);
   endfunction

endpackage

// File: rtl/cache_way.sv
// One cache way: valid bits (reset/invalidate), tag and line arrays.
// Asynchronous read by index, synchronous write; invalidate clears one index per cycle.
module cache_way #(
   parameter int unsigned SETS    = 16,
   parameter int unsigned INDEX_W = 4,
   parameter int unsigned TAG_W   = 26,
   parameter int unsigned LINE_W  = 32
) (
   input  logic               i_clk,
   input  logic               i_rst_n,
   input  logic [INDEX_W-1:0] i_rd_idx,
   output logic               o_valid,
   output logic [TAG_W-1:0]   o_tag,
   output logic [LINE_W-1:0]  o_line,
   input  logic               i_we,
   input  logic [INDEX_W-1:0] i_wr_idx,
   input  logic [TAG_W-1:0]   i_wr_tag,
   input  logic [LINE_W-1:0]  i_wr_line,
   input  logic               i_inv,
   input  logic [INDEX_W-1:0] i_inv_idx
);

   logic [SETS-1:0]   r_valid;
   logic [TAG_W-1:0]  r_tag  [SETS];
   logic [LINE_W-1:0] r_line [SETS];

   always_ff @(posedge i_clk) begin
      if (!i_rst_n) begin
         r_valid <= '0;
      end else begin
         if (i_inv) r_valid[i_inv_idx] <= 1'b0;
         if (i_we)  r_valid[i_wr_idx]  <= 1'b1;
      end
   end

   always_ff @(posedge i_clk) begin
      if (i_we) begin
         r_tag[i_wr_idx]  <= i_wr_tag;
         r_line[i_wr_idx] <= i_wr_line;
      end
   end

   assign o_valid = r_valid[i_rd_idx];
   assign o_tag   = r_tag[i_rd_idx];
   assign o_line  = r_line[i_rd_idx];

endmodule

// File: rtl/set_assoc_cache.sv
// 2-way set-associative read cache with LRU replacement, req/ack line refill and full flush.
// Define CACHE_STATS_EN to add saturating hit_count / miss_count outputs.
module set_assoc_cache
   import cache_pkg::*;
#(
   parameter int unsigned ADDR_W = 32,
   parameter int unsigned MEM_W  = 32,
   parameter int unsigned CORE_W = 8,
   parameter int unsigned SETS   = 16
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              core_req,
   input  logic [ADDR_W-1:0] core_addr,
   output logic              core_ready,
   output logic              core_valid,
   output logic [CORE_W-1:0] core_rdata,
   output logic              flag_hit,
   output logic              flag_miss,
   input  logic              flush,
   output logic              mem_req,
   output logic [ADDR_W-1:0] mem_addr,
`ifdef CACHE_STATS_EN
   output logic [31:0]       hit_count,
   output logic [31:0]       miss_count,
`endif
   input  logic              mem_ack,
   input  logic [MEM_W-1:0]  mem_rdata
);

   localparam int unsigned OFF_W   = calc_off_w(MEM_W, CORE_W);
   localparam int unsigned INDEX_W = calc_index_w(SETS);
   localparam int unsigned TAG_W   = calc_tag_w(ADDR_W, SETS, MEM_W, CORE_W);
   localparam int unsigned LANES   = MEM_W / CORE_W;

   cache_state_e r_state, w_state_d;

   logic [ADDR_W-1:0]  r_addr;
   logic [SETS-1:0]    r_lru;
   logic               r_hit;
   logic               r_way;
   logic               r_flush_pend;
   logic               r_rdy_en;
   logic [INDEX_W-1:0] r_flush_idx;

   logic [OFF_W-1:0]   w_off;
   logic [INDEX_W-1:0] w_idx;
   logic [TAG_W-1:0]   w_tag;
   logic [INDEX_W-1:0] w_way_idx;

   logic [1:0]              w_valid;
   logic [1:0][TAG_W-1:0]   w_way_tag;
   logic [1:0][MEM_W-1:0]   w_way_line;
   logic                    w_hit0, w_hit1, w_hit, w_hit_way, w_victim, w_fill, w_inv;
   logic [CORE_W-1:0]       w_lane;

   assign w_off = r_addr[OFF_W-1:0];
   assign w_idx = r_addr[OFF_W +: INDEX_W];
   assign w_tag = r_addr[ADDR_W-1 -: TAG_W];

   // Flush walks sets through the same read port the lookup uses
   assign w_way_idx = (r_state == StFlush) ? r_flush_idx : w_idx;
   assign w_fill    = (r_state == StRefill) && mem_ack;
   assign w_inv     = (r_state == StFlush);

   for (genvar g = 0; g < 2; g++) begin : g_way
      cache_way #(
         .SETS    (SETS),
         .INDEX_W (INDEX_W),
         .TAG_W   (TAG_W),
         .LINE_W  (MEM_W)
      ) u_way (
         .i_clk     (clk),
         .i_rst_n   (rst),
         .i_rd_idx  (w_way_idx),
         .o_valid   (w_valid[g]),
         .o_tag     (w_way_tag[g]),
         .o_line    (w_way_line[g]),
         .i_we      (w_fill && (r_way == 1'(g))),
         .i_wr_idx  (w_idx),
         .i_wr_tag  (w_tag),
         .i_wr_line (mem_rdata),
         .i_inv     (w_inv),
         .i_inv_idx (r_flush_idx)
      );
   end

   assign w_hit0    = w_valid[0] && (w_way_tag[0] == w_tag);
   assign w_hit1    = w_valid[1] && (w_way_tag[1] == w_tag);
   assign w_hit     = w_hit0 || w_hit1;
   assign w_hit_way = !w_hit0;
   assign w_victim  = !w_valid[0] ? 1'b0 : (!w_valid[1] ? 1'b1 : r_lru[w_idx]);

   always_comb begin
      w_lane = '0;
      for (int i = 0; i < LANES; i++) begin
         if (w_off == OFF_W'(i)) w_lane = w_way_line[r_way][i*CORE_W +: CORE_W];
      end
   end

   always_comb begin
      w_state_d  = r_state;
      core_ready = 1'b0;
      core_valid = 1'b0;
      core_rdata = '0;
      flag_hit   = 1'b0;
      flag_miss  = 1'b0;
      mem_req    = 1'b0;
      mem_addr   = '0;
      case (r_state)
         StIdle: begin
            core_ready = r_rdy_en && !r_flush_pend;
            if (flush || r_flush_pend)       w_state_d = StFlush;
            else if (core_req && core_ready) w_state_d = StLookup;
         end
         StLookup: begin
            flag_miss = !w_hit;
            w_state_d = w_hit ? StResp : StRefill;
         end
         StRefill: begin
            mem_req  = 1'b1;
            mem_addr = {w_tag, w_idx, {OFF_W{1'b0}}};
            if (mem_ack) w_state_d = StResp;
         end
         StResp: begin
            core_valid = 1'b1;
            core_rdata = w_lane;
            flag_hit   = r_hit;
            w_state_d  = (flush || r_flush_pend) ? StFlush : StIdle;
         end
         StFlush: begin
            if (r_flush_idx == INDEX_W'(SETS - 1)) w_state_d = StIdle;
         end
         default: w_state_d = StIdle;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         r_state      <= StIdle;
         r_addr       <= '0;
         r_lru        <= '0;
         r_hit        <= 1'b0;
         r_way        <= 1'b0;
         r_flush_pend <= 1'b0;
         r_rdy_en     <= 1'b0;
         r_flush_idx  <= '0;
      end else begin
         r_state  <= w_state_d;
         r_rdy_en <= 1'b1;
         if (r_state == StIdle && w_state_d == StLookup) r_addr <= core_addr;
         if (r_state == StLookup) begin
            r_hit <= w_hit;
            r_way <= w_hit ? w_hit_way : w_victim;
            if (w_hit) r_lru[w_idx] <= !w_hit_way;
         end
         if (w_fill) r_lru[w_idx] <= !r_way;
         if (r_state == StFlush) begin
            r_lru[r_flush_idx] <= 1'b0;
            r_flush_idx        <= r_flush_idx + 1'b1;
            r_flush_pend       <= 1'b0;
         end else begin
            r_flush_idx <= '0;
            if (flush && r_state != StIdle) r_flush_pend <= 1'b1;
         end
      end
   end

`ifdef CACHE_STATS_EN
   logic [31:0] r_hit_count, r_miss_count;

   always_ff @(posedge clk) begin
      if (!rst) begin
         r_hit_count  <= '0;
         r_miss_count <= '0;
      end else begin
         if (flag_hit && r_hit_count != '1)   r_hit_count  <= r_hit_count + 1'b1;
         if (flag_miss && r_miss_count != '1) r_miss_count <= r_miss_count + 1'b1;
      end
   end

   assign hit_count  = r_hit_count;
   assign miss_count = r_miss_count;
`endif

endmodule

// File: tb/tb_set_assoc_cache.sv
// Directed self-checking bench for set_assoc_cache; memory returns line = addr ^ 32'hDEADBEEF.
// Stats checks are compiled in when CACHE_STATS_EN is defined.
module tb_set_assoc_cache;

   logic        clk = 1'b0;
   logic        rst;
   logic        core_req;
   logic [31:0] core_addr;
   logic        core_ready;
   logic        core_valid;
   logic [7:0]  core_rdata;
   logic        flag_hit;
   logic        flag_miss;
   logic        flush;
   logic        mem_req;
   logic [31:0] mem_addr;
   logic        mem_ack;
   logic [31:0] mem_rdata;
`ifdef CACHE_STATS_EN
   logic [31:0] hit_count;
   logic [31:0] miss_count;
`endif

   int n_cmp = 0;
   int n_bad = 0;

   always #5 clk = ~clk;

   set_assoc_cache u_dut (
      .clk        (clk),
      .rst        (rst),
      .core_req   (core_req),
      .core_addr  (core_addr),
      .core_ready (core_ready),
      .core_valid (core_valid),
      .core_rdata (core_rdata),
      .flag_hit   (flag_hit),
      .flag_miss  (flag_miss),
      .flush      (flush),
      .mem_req    (mem_req),
      .mem_addr   (mem_addr),
`ifdef CACHE_STATS_EN
      .hit_count  (hit_count),
      .miss_count (miss_count),
`endif
      .mem_ack    (mem_ack),
      .mem_rdata  (mem_rdata)
   );

   function automatic logic [31:0] line_of(input logic [31:0] a);
      return a ^ 32'hDEAD_BEEF;
   endfunction

   // One read transaction; inputs driven and outputs sampled on negedges.
   // lat counts negedges after the accept edge until core_valid (-1 on timeout).
   task automatic do_read(input logic [31:0] addr, input int ack_lat, input int flush_at,
                          output logic miss, output logic hit, output logic [7:0] data,
                          output int lat, output logic [31:0] maddr, output int req_cyc);
      int w;
      miss = 1'b0; hit = 1'b0; data = '0; lat = -1; maddr = '0; req_cyc = 0; w = 0;
      @(negedge clk);
      while (!core_ready && w < 50) begin
         @(negedge clk);
         w++;
      end
      core_req  = 1'b1;
      core_addr = addr;
      @(negedge clk);
      core_req = 1'b0;
      for (int n = 1; n <= 60; n++) begin
         flush   = (n == flush_at);
         mem_ack = 1'b0;
         if (flag_miss) miss = 1'b1;
         if (mem_req) begin
            req_cyc++;
            maddr = mem_addr;
            if (req_cyc == ack_lat) begin
               mem_ack   = 1'b1;
               mem_rdata = line_of(mem_addr);
            end
         end
         if (core_valid) begin
            hit  = flag_hit;
            data = core_rdata;
            lat  = n;
            break;
         end
         @(negedge clk);
      end
      flush   = 1'b0;
      mem_ack = 1'b0;
   endtask

   task automatic test_reset();
      rst = 1'b0; core_req = 1'b0; core_addr = '0; flush = 1'b0;
      mem_ack = 1'b0; mem_rdata = '0;
      repeat (3) @(negedge clk);
      n_cmp++;
      if ({core_ready, core_valid, flag_hit, flag_miss, mem_req} !== 5'b0) begin
         n_bad++;
         $display("FAIL reset_flags: got %b want 00000",
                  {core_ready, core_valid, flag_hit, flag_miss, mem_req});
      end
      n_cmp++;
      if ({core_rdata, mem_addr} !== 40'h0) begin
         n_bad++;
         $display("FAIL reset_data: got rdata %h addr %h want 0", core_rdata, mem_addr);
      end
      rst = 1'b1;
      n_cmp++;
      if (core_ready !== 1'b0) begin
         n_bad++;
         $display("FAIL ready_before_release: got %b want 0", core_ready);
      end
      @(negedge clk);
      n_cmp++;
      if (core_ready !== 1'b1) begin
         n_bad++;
         $display("FAIL ready_after_release: got %b want 1", core_ready);
      end
   endtask

   task automatic test_miss_fill();
      logic miss, hit; logic [7:0] d; int lat; logic [31:0] ma; int rc;
      do_read(32'h1461, 3, 0, miss, hit, d, lat, ma, rc);
      n_cmp++;
      if (miss !== 1'b1) begin n_bad++; $display("FAIL s1_miss: got %b want 1", miss); end
      n_cmp++;
      if (ma !== 32'h1460) begin n_bad++; $display("FAIL s1_mem_addr: got %h want 1460", ma); end
      n_cmp++;
      if (d !== 8'hAA) begin n_bad++; $display("FAIL s1_rdata: got %h want aa", d); end
      n_cmp++;
      if (hit !== 1'b0) begin n_bad++; $display("FAIL s1_hit: got %b want 0", hit); end
      n_cmp++;
      if (lat !== 5) begin n_bad++; $display("FAIL s1_latency: got %0d want 5", lat); end
      n_cmp++;
      if (rc !== 3) begin n_bad++; $display("FAIL s1_req_cycles: got %0d want 3", rc); end
   endtask

   task automatic test_hit();
      logic miss, hit; logic [7:0] d; int lat; logic [31:0] ma; int rc;
      do_read(32'h1461, 3, 0, miss, hit, d, lat, ma, rc);
      n_cmp++;
      if ({hit, miss} !== 2'b10) begin
         n_bad++; $display("FAIL s2_hit_miss: got %b%b want 10", hit, miss);
      end
      n_cmp++;
      if (lat !== 2) begin n_bad++; $display("FAIL s2_latency: got %0d want 2", lat); end
      n_cmp++;
      if (rc !== 0) begin n_bad++; $display("FAIL s2_mem_req: got %0d want 0", rc); end
      n_cmp++;
      if (d !== 8'hAA) begin n_bad++; $display("FAIL s2_rdata: got %h want aa", d); end
   endtask

   task automatic test_lru();
      logic miss, hit; logic [7:0] d; int lat; logic [31:0] ma; int rc;
      do_read(32'hF261, 3, 0, miss, hit, d, lat, ma, rc);
      n_cmp++;
      if ({miss, d} !== {1'b1, 8'h4C}) begin
         n_bad++; $display("FAIL s3_f261_fill: got miss %b data %h want 1 4c", miss, d);
      end
      do_read(32'h8861, 3, 0, miss, hit, d, lat, ma, rc);
      n_cmp++;
      if ({miss, ma, d} !== {1'b1, 32'h8860, 8'h36}) begin
         n_bad++;
         $display("FAIL s3_8861_fill: got miss %b addr %h data %h want 1 8860 36", miss, ma, d);
      end
      do_read(32'hF261, 3, 0, miss, hit, d, lat, ma, rc);
      n_cmp++;
      if ({hit, miss, d} !== {2'b10, 8'h4C}) begin
         n_bad++; $display("FAIL s3_f261_hit: got hit %b miss %b data %h want 1 0 4c", hit, miss, d);
      end
      do_read(32'h1461, 3, 0, miss, hit, d, lat, ma, rc);
      n_cmp++;
      if ({hit, miss, d} !== {2'b01, 8'hAA}) begin
         n_bad++; $display("FAIL s3_1461_evicted: got hit %b miss %b data %h want 0 1 aa", hit, miss, d);
      end
   endtask

`ifdef CACHE_STATS_EN
   task automatic test_stats();
      n_cmp++;
      if ({hit_count, miss_count} !== {32'd2, 32'd4}) begin
         n_bad++; $display("FAIL stats_s123: got %0d/%0d want 2/4", hit_count, miss_count);
      end
   endtask
`endif

   task automatic test_byte_lanes();
      logic miss, hit; logic [7:0] d; int lat; logic [31:0] ma; int rc;
      do_read(32'h1460, 3, 0, miss, hit, d, lat, ma, rc);
      n_cmp++;
      if ({hit, d} !== {1'b1, 8'h8F}) begin
         n_bad++; $display("FAIL lane0: got hit %b data %h want 1 8f", hit, d);
      end
      do_read(32'h1462, 3, 0, miss, hit, d, lat, ma, rc);
      n_cmp++;
      if ({hit, d} !== {1'b1, 8'hAD}) begin
         n_bad++; $display("FAIL lane2: got hit %b data %h want 1 ad", hit, d);
      end
      do_read(32'h1463, 3, 0, miss, hit, d, lat, ma, rc);
      n_cmp++;
      if ({hit, d} !== {1'b1, 8'hDE}) begin
         n_bad++; $display("FAIL lane3: got hit %b data %h want 1 de", hit, d);
      end
   endtask

   task automatic test_flush();
      logic miss, hit; logic [7:0] d; int lat; logic [31:0] ma; int rc;
      int busy; logic vseen;
      do_read(32'h512D, 3, 3, miss, hit, d, lat, ma, rc);
      n_cmp++;
      if ({miss, d, lat} !== {1'b1, 8'hEF, 32'd5}) begin
         n_bad++;
         $display("FAIL s4_inflight: got miss %b data %h lat %0d want 1 ef 5", miss, d, lat);
      end
      busy = 0; vseen = 1'b0;
      for (int k = 0; k < 40; k++) begin
         @(negedge clk);
         if (core_ready) break;
         if (core_valid) vseen = 1'b1;
         busy++;
      end
      n_cmp++;
      if (busy !== 16) begin n_bad++; $display("FAIL s4_flush_len: got %0d want 16", busy); end
`ifdef CACHE_STATS_EN
      n_cmp++;
      if ({hit_count, miss_count} !== {32'd5, 32'd5}) begin
         n_bad++; $display("FAIL stats_flush: got %0d/%0d want 5/5", hit_count, miss_count);
      end
`endif
      do_read(32'h512D, 3, 0, miss, hit, d, lat, ma, rc);
      n_cmp++;
      if ({hit, miss, d} !== {2'b01, 8'hEF}) begin
         n_bad++; $display("FAIL s4_after_flush: got hit %b miss %b data %h want 0 1 ef", hit, miss, d);
      end
      // Flush and request together in IDLE: request must be dropped
      @(negedge clk);
      flush = 1'b1; core_req = 1'b1; core_addr = 32'h512D;
      busy = 0;
      for (int k = 0; k < 40; k++) begin
         @(negedge clk);
         flush = 1'b0; core_req = 1'b0;
         if (core_ready) break;
         if (core_valid) vseen = 1'b1;
         busy++;
      end
      n_cmp++;
      if ({busy, vseen} !== {32'd16, 1'b0}) begin
         n_bad++; $display("FAIL flush_wins: got busy %0d valid %b want 16 0", busy, vseen);
      end
      do_read(32'h512D, 3, 0, miss, hit, d, lat, ma, rc);
      n_cmp++;
      if ({hit, miss} !== 2'b01) begin
         n_bad++; $display("FAIL flush_wins_miss: got hit %b miss %b want 0 1", hit, miss);
      end
   endtask

   task automatic test_reset_mid_refill();
      logic miss, hit; logic [7:0] d; int lat; logic [31:0] ma; int rc;
      int w;
      w = 0;
      @(negedge clk);
      while (!core_ready && w < 50) begin @(negedge clk); w++; end
      core_req = 1'b1; core_addr = 32'h2001;
      @(negedge clk);
      core_req = 1'b0;
      w = 0;
      while (!mem_req && w < 20) begin @(negedge clk); w++; end
      n_cmp++;
      if (mem_req !== 1'b1) begin n_bad++; $display("FAIL s5_req_seen: got %b want 1", mem_req); end
      rst = 1'b0;
      @(negedge clk);
      n_cmp++;
      if ({mem_req, core_ready} !== 2'b00) begin
         n_bad++; $display("FAIL s5_req_drop: got req %b ready %b want 0 0", mem_req, core_ready);
      end
      rst = 1'b1;
      @(negedge clk);
      mem_ack = 1'b1; mem_rdata = 32'h1234_5678;
      @(negedge clk);
      mem_ack = 1'b0;
      n_cmp++;
      if ({core_valid, mem_req, core_ready} !== 3'b001) begin
         n_bad++;
         $display("FAIL s5_stray_ack: got valid %b req %b ready %b want 0 0 1",
                  core_valid, mem_req, core_ready);
      end
      do_read(32'h2001, 3, 0, miss, hit, d, lat, ma, rc);
      n_cmp++;
      if ({miss, ma, d} !== {1'b1, 32'h2000, 8'h9E}) begin
         n_bad++;
         $display("FAIL s5_next_miss: got miss %b addr %h data %h want 1 2000 9e", miss, ma, d);
      end
   endtask

   task automatic test_back_to_back();
      int nv, nh, nr, w; logic [7:0] last;
      nv = 0; nh = 0; nr = 0; w = 0; last = '0;
      @(negedge clk);
      while (!core_ready && w < 50) begin @(negedge clk); w++; end
      core_req = 1'b1; core_addr = 32'h2003;
      for (int k = 0; k < 9; k++) begin
         @(negedge clk);
         if (core_valid) begin nv++; last = core_rdata; end
         if (flag_hit) nh++;
         if (mem_req) nr++;
      end
      core_req = 1'b0;
      n_cmp++;
      if ({nv, nh, nr} !== {32'd3, 32'd3, 32'd0}) begin
         n_bad++; $display("FAIL b2b_throughput: got valid %0d hit %0d req %0d want 3 3 0", nv, nh, nr);
      end
      n_cmp++;
      if (last !== 8'hDE) begin n_bad++; $display("FAIL b2b_rdata: got %h want de", last); end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, got timeout want completion");
      $fatal(1);
   end

   initial begin
      test_reset();
      test_miss_fill();
      test_hit();
      test_lru();
`ifdef CACHE_STATS_EN
      test_stats();
`endif
      test_byte_lanes();
      test_flush();
      test_reset_mid_refill();
      test_back_to_back();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
